player_move_rect: RTL and testbench

Upstream neighbour of the player bitmap stage. Owns the player's on-screen position: it updates the top-left corner once per frame from the left/right buttons, clamps it to the play-field walls, and freezes it on a hit. Every pixel clock it compares the VGA scan position against the player rectangle. It hands the bitmap stage a registered `InsideRectangle` flag plus `offsetX`/`offsetY` relative to the top-left corner.

---
 rtl/player_pkg.sv | 16 +
 rtl/player_rect.sv | 38 +++
 rtl/player_move_rect.sv | 81 ++++++++
 tb/tb_player_move_rect.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/player_pkg.sv
// player_pkg: shared screen/sprite constants and movement state encoding
package player_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MOVE_L = 2'd1,
        MOVE_R = 2'd2,
        FROZEN = 2'd3
    } move_state_t;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int PLAYER_W = 26;
    localparam int PLAYER_H = 26;

endpackage

// File: rtl/player_rect.sv
// player_rect: registered scan-pixel vs. rectangle test with offsets from the top-left corner
module player_rect #(
    parameter int OBJECT_WIDTH_X  = 26,
    parameter int OBJECT_HEIGHT_Y = 26
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] pixelX,
    input  logic [10:0] pixelY,
    input  logic [10:0] topLeftX,
    input  logic [10:0] topLeftY,
    output logic        InsideRectangle,
    output logic [10:0] offsetX,
    output logic [10:0] offsetY
);

    logic [11:0] end_x, end_y;
    logic        hit;

    assign end_x = {1'b0, topLeftX} + 12'(OBJECT_WIDTH_X);
    assign end_y = {1'b0, topLeftY} + 12'(OBJECT_HEIGHT_Y);
    assign hit   = pixelX >= topLeftX && {1'b0, pixelX} < end_x &&
                   pixelY >= topLeftY && {1'b0, pixelY} < end_y;

    // one-cycle registered hit flag and offsets, zeroed outside the sprite
    always_ff @(posedge clk) begin
        if (reset) begin
            InsideRectangle <= 1'b0;
            offsetX         <= '0;
            offsetY         <= '0;
        end else begin
            InsideRectangle <= hit;
            offsetX         <= hit ? pixelX - topLeftX : '0;
            offsetY         <= hit ? pixelY - topLeftY : '0;
        end
    end

endmodule

// File: rtl/player_move_rect.sv
// player_move_rect: per-frame player movement FSM with wall clamping and registered rectangle test
module player_move_rect
    import player_pkg::*;
#(
    parameter int OBJECT_WIDTH_X  = PLAYER_W,
    parameter int OBJECT_HEIGHT_Y = PLAYER_H,
    parameter int LEFT_BOUND      = 0,
    parameter int RIGHT_BOUND     = SCREEN_W - 1,
    parameter int INITIAL_X       = 307,
    parameter int FLOOR_Y         = 430,
    parameter int SPEED           = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        startOfFrame,
    input  logic        leftPress,
    input  logic        rightPress,
    input  logic        freeze,
    input  logic [10:0] pixelX,
    input  logic [10:0] pixelY,
    output logic        InsideRectangle,
    output logic [10:0] offsetX,
    output logic [10:0] offsetY,
    output logic [10:0] topLeftX,
    output logic [10:0] topLeftY,
    output logic [1:0]  moveState
);

    localparam logic [11:0] MAX_X   = 12'(RIGHT_BOUND - OBJECT_WIDTH_X + 1);
    localparam logic [11:0] L_LIMIT = 12'(LEFT_BOUND + SPEED);

    move_state_t state, next_state;
    logic [10:0] pos_x, next_x;

    // decode buttons only at the frame pulse; freeze dominates, conflicting or no buttons idle
    always_comb begin
        next_state = state;
        next_x     = pos_x;
        if (startOfFrame) begin
            next_state = freeze ? FROZEN :
                         (leftPress == rightPress) ? IDLE :
                         leftPress ? MOVE_L : MOVE_R;
            next_x = (next_state == MOVE_L) ?
                         (({1'b0, pos_x} < L_LIMIT) ? 11'(LEFT_BOUND) : pos_x - 11'(SPEED)) :
                     (next_state == MOVE_R) ?
                         (({1'b0, pos_x} + 12'(SPEED) > MAX_X) ? MAX_X[10:0] : pos_x + 11'(SPEED)) :
                     pos_x;
        end
    end

    // state and position registers; reset overrides a coincident frame pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            pos_x <= 11'(INITIAL_X);
        end else begin
            state <= next_state;
            pos_x <= next_x;
        end
    end

    assign topLeftX  = pos_x;
    assign topLeftY  = 11'(FLOOR_Y);
    assign moveState = state;

    player_rect #(
        .OBJECT_WIDTH_X (OBJECT_WIDTH_X),
        .OBJECT_HEIGHT_Y(OBJECT_HEIGHT_Y)
    ) u_rect (
        .clk            (clk),
        .reset          (reset),
        .pixelX         (pixelX),
        .pixelY         (pixelY),
        .topLeftX       (pos_x),
        .topLeftY       (topLeftY),
        .InsideRectangle(InsideRectangle),
        .offsetX        (offsetX),
        .offsetY        (offsetY)
    );

endmodule

// File: tb/tb_player_move_rect.sv
// tb_player_move_rect: directed plus randomized checks against a frame-level player model
module tb_player_move_rect;

    logic        clk = 1'b0;
    logic        reset, startOfFrame, leftPress, rightPress, freeze;
    logic [10:0] pixelX, pixelY;
    logic        InsideRectangle;
    logic [10:0] offsetX, offsetY, topLeftX, topLeftY;
    logic [1:0]  moveState;

    int n_cmp = 0;
    int n_bad = 0;

    int mx = 307;
    int ms = 0;
    int e_in = 0, e_ox = 0, e_oy = 0;

    always #5 clk = ~clk;

    player_move_rect dut (
        .clk            (clk),
        .reset          (reset),
        .startOfFrame   (startOfFrame),
        .leftPress      (leftPress),
        .rightPress     (rightPress),
        .freeze         (freeze),
        .pixelX         (pixelX),
        .pixelY         (pixelY),
        .InsideRectangle(InsideRectangle),
        .offsetX        (offsetX),
        .offsetY        (offsetY),
        .topLeftX       (topLeftX),
        .topLeftY       (topLeftY),
        .moveState      (moveState)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("topLeftX", 32'(topLeftX), mx);
        check("topLeftY", 32'(topLeftY), 430);
        check("moveState", 32'(moveState), ms);
        check("inside", 32'(InsideRectangle), e_in);
        check("offsetX", 32'(offsetX), e_ox);
        check("offsetY", 32'(offsetY), e_oy);
    endtask

    // one clock: drive at negedge, advance the model, compare just after posedge
    task automatic step(input bit r, input bit s, input bit l, input bit rt, input bit f,
                        input int px, input int py);
        @(negedge clk);
        reset = r; startOfFrame = s; leftPress = l; rightPress = rt; freeze = f;
        pixelX = 11'(px); pixelY = 11'(py);
        if (r) begin
            mx = 307; ms = 0; e_in = 0; e_ox = 0; e_oy = 0;
        end else begin
            e_in = (px >= mx && px < mx + 26 && py >= 430 && py < 456) ? 1 : 0;
            e_ox = e_in ? px - mx : 0;
            e_oy = e_in ? py - 430 : 0;
            if (s) begin
                ms = f ? 3 : (l == rt) ? 0 : l ? 1 : 2;
                if (ms == 1) mx = (mx - 4 < 0) ? 0 : mx - 4;
                if (ms == 2) mx = (mx + 4 > 614) ? 614 : mx + 4;
            end
        end
        @(posedge clk);
        #1;
        check_all();
    endtask

    function automatic int rnd_px();
        return ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 2047))
                                           : int'($urandom_range(mx + 28, (mx >= 3) ? mx - 3 : 0));
    endfunction

    function automatic int rnd_py();
        return ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 2047))
                                           : int'($urandom_range(426, 460));
    endfunction

    // a frame pulse followed by one ordinary scan cycle
    task automatic frame(input bit l, input bit rt, input bit f);
        step(0, 1, l, rt, f, rnd_px(), rnd_py());
        step(0, 0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 0, rnd_px(), rnd_py());
    endtask

    initial begin
        reset = 1; startOfFrame = 0; leftPress = 0; rightPress = 0; freeze = 0;
        pixelX = 0; pixelY = 0;
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 310, 440);

        frame(0, 1, 0); check("right1", 32'(topLeftX), 311);
        frame(0, 1, 0); check("right2", 32'(topLeftX), 315);
        frame(0, 1, 0); check("right3", 32'(topLeftX), 319);
        check("right_state", 32'(moveState), 2);

        for (int i = 0; i < 82; i++) frame(1, 0, 0);
        check("left_wall", 32'(topLeftX), 0);
        for (int i = 0; i < 153; i++) frame(0, 1, 0);
        check("at612", 32'(topLeftX), 612);
        frame(0, 1, 0); check("clamp_r", 32'(topLeftX), 614);
        frame(0, 1, 0); check("hold_r", 32'(topLeftX), 614);
        check("hold_r_state", 32'(moveState), 2);

        for (int i = 0; i < 153; i++) frame(1, 0, 0);
        check("at2", 32'(topLeftX), 2);
        frame(1, 0, 0); check("clamp_l", 32'(topLeftX), 0);
        frame(1, 0, 0); check("hold_l", 32'(topLeftX), 0);
        check("hold_l_state", 32'(moveState), 1);

        for (int i = 0; i < 25; i++) frame(0, 1, 0);
        frame(1, 1, 0); check("both_idle", 32'(moveState), 0);
        check("both_x", 32'(topLeftX), 100);
        frame(0, 1, 1); check("frz_state", 32'(moveState), 3);
        check("frz_x", 32'(topLeftX), 100);
        step(0, 0, 0, 1, 0, 0, 0); check("between_frames", 32'(topLeftX), 100);
        frame(0, 1, 0); check("unfrz_state", 32'(moveState), 2);
        check("unfrz_x", 32'(topLeftX), 104);
        for (int i = 0; i < 1; i++) frame(1, 0, 0);
        check("back100", 32'(topLeftX), 100);

        step(0, 0, 0, 0, 0, 125, 455); check("corner_in", 32'(InsideRectangle), 1);
        check("corner_ox", 32'(offsetX), 25);
        check("corner_oy", 32'(offsetY), 25);
        step(0, 0, 0, 0, 0, 126, 455); check("right_out", 32'(InsideRectangle), 0);
        check("right_out_ox", 32'(offsetX), 0);
        step(0, 0, 0, 0, 0, 100, 430);
        step(0, 0, 0, 0, 0, 99, 430);
        step(0, 0, 0, 0, 0, 100, 429);
        step(0, 0, 0, 0, 0, 125, 456);
        step(0, 0, 0, 0, 0, 110, 440);

        for (int i = 0; i < 75; i++) frame(0, 1, 0);
        check("at400", 32'(topLeftX), 400);
        step(0, 0, 0, 0, 0, 410, 440);
        step(1, 1, 0, 1, 0, 410, 440);
        check("rst_x", 32'(topLeftX), 307);
        check("rst_state", 32'(moveState), 0);
        check("rst_in", 32'(InsideRectangle), 0);
        step(0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 600; i++)
            step(0, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0, rnd_px(), rnd_py());

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
